// File: rtl/buck_sys_top.sv
// buck_sys_top: fixed-point, real-time forward-Euler model of an ideal buck
// converter (switch, L, C, resistive load). One integration step runs every
// STEP_DIV clock cycles. An internal PWM counter drives the switch.
// All values are signed Q8.8. Every sum saturates to 16 bits and never wraps.
module buck_sys_top #(
  parameter logic signed [15:0] VIN        = 16'sd3072,
  parameter logic signed [15:0] KL         = 16'sd26,
  parameter logic signed [15:0] KC         = 16'sd26,
  parameter logic signed [15:0] GR         = 16'sd64,
  parameter int                 PWM_PERIOD = 100,
  parameter int                 DUTY       = 50,
  parameter int                 STEP_DIV   = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic signed [15:0] v_1i_o,
  output logic signed [15:0] v_2i_o,
  output logic signed [15:0] v_1d_o,
  output logic signed [15:0] v_2d_o
);

  localparam int CNT_W = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_PERIOD - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [31:0]      DUTY_U   = 32'(DUTY);

  // Clamp a wide signed intermediate into the 16-bit Q8.8 range.
  function automatic logic signed [15:0] sat16(input logic signed [33:0] x);
    logic signed [15:0] y;
    if (x > 34'sd32767) begin
      y = 16'sh7FFF;
    end else if (x < -34'sd32768) begin
      y = 16'sh8000;
    end else begin
      y = x[15:0];
    end
    return y;
  endfunction

  logic [DIV_W-1:0]   r_div;
  logic [CNT_W-1:0]   r_pwm_cnt;
  logic signed [15:0] r_v1i;
  logic signed [15:0] r_v2i;
  logic signed [15:0] r_v1d;
  logic signed [15:0] r_v2d;

  logic               w_step;
  logic               w_sw;
  logic signed [17:0] w_d1_sum;
  logic signed [15:0] w_d1;
  logic signed [15:0] w_d2;
  logic signed [31:0] w_p_gr;
  logic signed [31:0] w_p_kl;
  logic signed [31:0] w_p_kc;
  logic signed [15:0] w_v1_nxt;
  logic signed [15:0] w_v2_nxt;

  assign w_step = (r_div == DIV_LAST);

  // The switch is closed for the first DUTY steps of each PWM period.
  // The comparison runs at 32 bits so that DUTY >= PWM_PERIOD means always on.
  assign w_sw = (32'(r_pwm_cnt) < DUTY_U);

  // Inductor voltage: source minus output while the switch is closed,
  // otherwise the freewheeling path applies -v_2i.
  always_comb begin
    w_d1_sum = 18'sd0;
    if (w_sw) begin
      w_d1_sum = 18'(VIN) - 18'(r_v2i);
    end else begin
      w_d1_sum = 18'sd0 - 18'(r_v2i);
    end
  end

  assign w_d1     = sat16(34'(w_d1_sum));
  assign w_p_gr   = r_v2i * GR;
  assign w_d2     = sat16(34'(r_v1i) - 34'(w_p_gr >>> 8));
  assign w_p_kl   = w_d1 * KL;
  assign w_p_kc   = w_d2 * KC;
  assign w_v1_nxt = sat16(34'(r_v1i) + 34'(w_p_kl >>> 8));
  assign w_v2_nxt = sat16(34'(r_v2i) + 34'(w_p_kc >>> 8));

  // Prescaler: the step enable fires on the last cycle of each STEP_DIV window.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_div <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // PWM step counter: advances once per step and wraps after PWM_PERIOD steps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pwm_cnt <= '0;
    end else if (w_step) begin
      if (r_pwm_cnt == CNT_LAST) begin
        r_pwm_cnt <= '0;
      end else begin
        r_pwm_cnt <= r_pwm_cnt + CNT_W'(1);
      end
    end
  end

  // Euler integration. Every term comes from the values held before the step.
  // Reset takes priority over the step enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_v1i <= 16'sd0;
      r_v2i <= 16'sd0;
      r_v1d <= 16'sd0;
      r_v2d <= 16'sd0;
    end else if (w_step) begin
      r_v1i <= w_v1_nxt;
      r_v2i <= w_v2_nxt;
      r_v1d <= w_d1;
      r_v2d <= w_d2;
    end
  end

  assign v_1i_o = r_v1i;
  assign v_2i_o = r_v2i;
  assign v_1d_o = r_v1d;
  assign v_2d_o = r_v2d;

endmodule

// File: tb/tb_buck_sys_top.sv
// Directed bench for buck_sys_top. It runs five instances side by side:
// default parameters, always-on switch, saturation, STEP_DIV=4 and DUTY=0.
module tb_buck_sys_top;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d;  // reset for the default instance, which gets its own mid-run reset
  logic rst_o;  // reset shared by all other instances

  logic signed [15:0] d_1i, d_2i, d_1d, d_2d;  // default instance
  logic signed [15:0] f_1i, f_2i, f_1d, f_2d;  // DUTY = PWM_PERIOD
  logic signed [15:0] s_1i, s_2i, s_1d, s_2d;  // saturation
  logic signed [15:0] q_1i, q_2i, q_1d, q_2d;  // STEP_DIV = 4
  logic signed [15:0] z_1i, z_2i, z_1d, z_2d;  // DUTY = 0

  buck_sys_top u_dflt (.clk_i(clk), .rst_i(rst_d),
    .v_1i_o(d_1i), .v_2i_o(d_2i), .v_1d_o(d_1d), .v_2d_o(d_2d));

  buck_sys_top #(.DUTY(100)) u_full (.clk_i(clk), .rst_i(rst_o),
    .v_1i_o(f_1i), .v_2i_o(f_2i), .v_1d_o(f_1d), .v_2d_o(f_2d));

  buck_sys_top #(.VIN(16'sd32767), .KL(16'sd256), .KC(16'sd256), .GR(16'sd0), .DUTY(100))
    u_sat (.clk_i(clk), .rst_i(rst_o),
    .v_1i_o(s_1i), .v_2i_o(s_2i), .v_1d_o(s_1d), .v_2d_o(s_2d));

  buck_sys_top #(.STEP_DIV(4)) u_div4 (.clk_i(clk), .rst_i(rst_o),
    .v_1i_o(q_1i), .v_2i_o(q_2i), .v_1d_o(q_1d), .v_2d_o(q_2d));

  buck_sys_top #(.DUTY(0)) u_off (.clk_i(clk), .rst_i(rst_o),
    .v_1i_o(z_1i), .v_2i_o(z_2i), .v_1d_o(z_1d), .v_2d_o(z_2d));

  int n_err = 0;
  int n_chk = 0;
  int ks = 0;        // steps since rst_o was released
  bit sat_neg = 1'b0;
  int prev_v2 = 0;

  // Expected values for the first three steps with default parameters, worked out by hand
  int e1i [3] = '{312, 624, 932};
  int e2i [3] = '{0, 31, 93};
  int e1d [3] = '{3072, 3072, 3041};
  int e2d [3] = '{0, 312, 617};

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    ks++;
    if (s_1i < 16'sd0) sat_neg = 1'b1;
  endtask

  task automatic chk_dflt_zero(input string tag);
    chk({tag, "_1i"}, int'(d_1i), 0);
    chk({tag, "_2i"}, int'(d_2i), 0);
    chk({tag, "_1d"}, int'(d_1d), 0);
    chk({tag, "_2d"}, int'(d_2d), 0);
  endtask

  initial begin
    int idx;
    rst_d = 1'b1;
    rst_o = 1'b1;

    // Hold reset for 3 cycles: outputs stay zero throughout
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_dflt_zero($sformatf("rst%0d", i));
      chk($sformatf("rst%0d_q1i", i), int'(q_1i), 0);
    end
    rst_d = 1'b0;
    rst_o = 1'b0;
    ks = 0;

    // First 500 steps
    for (int k = 1; k <= 500; k++) begin
      tick();
      if (k <= 3) begin
        chk($sformatf("s%0d_1i", k), int'(d_1i), e1i[k-1]);
        chk($sformatf("s%0d_2i", k), int'(d_2i), e2i[k-1]);
        chk($sformatf("s%0d_1d", k), int'(d_1d), e1d[k-1]);
        chk($sformatf("s%0d_2d", k), int'(d_2d), e2d[k-1]);
      end
      // STEP_DIV=4 instance: changes only on every 4th edge and then holds the last value
      if (k <= 12) begin
        idx = k / 4 - 1;
        chk($sformatf("div4_e%0d_1i", k), int'(q_1i), (idx < 0) ? 0 : e1i[idx]);
        chk($sformatf("div4_e%0d_2i", k), int'(q_2i), (idx < 0) ? 0 : e2i[idx]);
        chk($sformatf("div4_e%0d_1d", k), int'(q_1d), (idx < 0) ? 0 : e1d[idx]);
        chk($sformatf("div4_e%0d_2d", k), int'(q_2d), (idx < 0) ? 0 : e2d[idx]);
      end
      if (k == 50)  chk("pwm50_pos", int'(d_1d > 16'sd0), 1);
      if (k == 51) begin
        chk("pwm51_val", int'(d_1d), -prev_v2);
        chk("pwm51_neg", int'(d_1d < 16'sd0), 1);
      end
      if (k == 100) chk("pwm100_neg", int'(d_1d < 16'sd0), 1);
      if (k == 101) begin
        chk("pwm101_val", int'(d_1d), 3072 - prev_v2);
        chk("pwm101_pos", int'(d_1d > 16'sd0), 1);
      end
      if (k == 1) chk("sat_s1_1i", int'(s_1i), 32767);
      if (k == 2) begin
        chk("sat_s2_1i", int'(s_1i), 32767);
        chk("sat_s2_2i", int'(s_2i), 32767);
        chk("sat_s2_2d", int'(s_2d), 32767);
      end
      if (k == 3) chk("sat_s3_1d", int'(s_1d), 0);
      if (k == 1) chk("off_s1_1d", int'(z_1d), 0);
      if (k == 10) begin
        chk("off_s10_1i", int'(z_1i), 0);
        chk("off_s10_2i", int'(z_2i), 0);
      end
      prev_v2 = int'(d_2i);
    end

    // Reset in the middle of the run (default instance only), then restart from step 1
    rst_d = 1'b1;
    tick();
    chk_dflt_zero("midrst");
    rst_d = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("re%0d_1i", k), int'(d_1i), e1i[k-1]);
      chk($sformatf("re%0d_2i", k), int'(d_2i), e2i[k-1]);
      chk($sformatf("re%0d_1d", k), int'(d_1d), e1d[k-1]);
      chk($sformatf("re%0d_2d", k), int'(d_2d), e2d[k-1]);
    end

    // Run the other instances on to 20000 steps
    while (ks < 20000) tick();
    chk("full_v2_band", int'(f_2i >= 16'sd2980 && f_2i <= 16'sd3164), 1);
    chk("full_v1_band", int'(f_1i >= 16'sd745 && f_1i <= 16'sd791), 1);
    chk("sat_never_neg", int'(sat_neg), 0);
    chk("sat_end_1i", int'(s_1i), 32767);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
